ls86_xor_arbiter: RTL
=====================

Name: ls86_xor_arbiter

Overview:
Round-robin arbiter that shares one ls86_quad_xor instance (four 2-input XOR lanes) between N_REQ requesters. Each requester submits a 4-bit A/B operand pair over a valid/ready handshake. The arbiter sequences the shared gate and returns the 4-bit result over a per-requester response handshake. It sits between client logic blocks and the single shared quad-XOR datapath.

Parameters:
N_REQ, 4, number of requesters (1..16)
GID_W, $clog2(N_REQ) min 1, width of grant_id

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester request accept (one-hot or zero)
req_a  in  4*N_REQ  operand A; requester i occupies bits [4i+3:4i]; bit 0 drives lane 1
req_b  in  4*N_REQ  operand B; same packing as req_a
rsp_valid  out  N_REQ  per-requester result valid (one-hot or zero)
rsp_ready  in  N_REQ  per-requester result accept
rsp_y  out  4  result bus, shared by all requesters; bit k = lane k+1 output
grant_id  out  GID_W  index of the requester currently owning the gate
busy  out  1  high in EXEC and RESP

Behaviour:
- Reset (async assert, synchronous release): state=IDLE, ptr=0, grant_id=0, rsp_y=0, operand regs=0.
- Reset values also drive the outputs: rsp_valid=0, req_ready=0, busy=0.
- State machine: IDLE -> EXEC -> RESP -> IDLE.
- IDLE behaviour:
  - Winner = first i with req_valid[i]=1, searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[winner]=1 combinationally. All other req_ready bits are 0.
  - No valid request: no ready, stay IDLE.
  - On the handshake (same cycle), capture req_a/req_b slices into operand regs, set grant_id=winner, go EXEC.
- EXEC: operand regs drive the ls86_quad_xor instance. Register Y1..Y4 into rsp_y. Go RESP.
- RESP:
  - rsp_valid[grant_id]=1. rsp_y and grant_id are held stable.
  - When rsp_ready[grant_id]=1: ptr = (grant_id+1) mod N_REQ (N_REQ-1 wraps to 0), go IDLE.
  - No request is accepted in EXEC or RESP (all req_ready=0).
- Timing:
  - Request handshake at cycle T gives rsp_valid at T+2.
  - With rsp_ready tied high, rsp_valid stays one cycle and the next accept can be T+3.
  - Peak throughput is 1 op per 3 cycles.
- Fairness: a requester holding req_valid is granted within N_REQ grants.
- Boundary conditions:
  - req_valid dropped before handshake: legal, no grant, ptr unchanged.
  - Operands may change after handshake; the result reflects captured values only.
  - rsp_ready from a non-granted requester is ignored.
  - rsp_ready held high in advance completes the response in its first RESP cycle.
  - Backpressure in RESP is unbounded; state is held indefinitely.
  - N_REQ=1: requester 0 is always the winner, GID_W=1, grant_id=0.
  - Reset during EXEC/RESP aborts the transaction: no response, ptr=0.
  - Simultaneous requests are resolved purely by rotating priority, never by index alone.

Decomposition:
- Shared package ls86_pkg: state enum {IDLE, EXEC, RESP}; LANES=4 constant; round-robin pick function (request vector, ptr) -> index/found.
- One sub-module, instantiated once: ls86_quad_xor as the shared datapath.
- Arbitration and FSM stay in this module.

Test Plan:
1. Reset then idle (N_REQ=4, no req_valid for 10 cycles) -> all req_ready/rsp_valid 0, busy 0, rsp_y=0.
2. Single op (req 2: A=4'b1010, B=4'b0110, rsp_ready=1) -> req_ready[2] in cycle T; rsp_valid[2] at T+2 with rsp_y=4'b1100; grant_id=2.
3. Contention (all 4 requesters valid continuously, ptr=0 after reset) -> grant order 0,1,2,3,0.
   - Each result equals that requester's A^B, e.g. A=4'hF, B=4'h0 -> 4'hF; A=B -> 4'h0.
4. Backpressure (req 1 result, rsp_ready[1]=0 for 5 cycles, rsp_ready[3]=1 throughout) -> rsp_valid[1] and rsp_y held 5 cycles; req_valid[0] not accepted until after rsp_ready[1].
5. Wrap and skip (grant 3 completes, then only req 1 valid) -> ptr wraps to 0, req 1 granted next.
6. Async reset asserted mid-RESP -> rsp_valid drops immediately, state IDLE; next grant starts search from 0.

Source files
------------

// File: rtl/ls86_pkg.sv
// Shared types and helpers for the quad-XOR arbiter: FSM states, lane count
// and the rotating-priority pick used to choose the next gate owner.
package ls86_pkg;

    localparam int LANES     = 4;
    localparam int MAX_REQ   = 16;
    localparam int MAX_GID_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef struct packed {
        logic                 found;
        logic [MAX_GID_W-1:0] idx;
    } rr_pick_t;

    // Scanned from the far end so the candidate closest to ptr is the one kept.
    function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   req,
                                         input logic [MAX_GID_W-1:0] ptr,
                                         input int                   n);
        rr_pick_t res;
        int       cand;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (k < n) begin
                cand = (int'(ptr) + k) % n;
                if (req[cand]) begin
                    res.found = 1'b1;
                    res.idx   = MAX_GID_W'(cand);
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ls86_quad_xor.sv
// Four independent 2-input XOR lanes; lane k+1 maps to bit k.
module ls86_quad_xor
    import ls86_pkg::*;
(
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    output logic [LANES-1:0] y
);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign y[gi] = a[gi] ^ b[gi];
    end

endmodule

// File: rtl/ls86_xor_arbiter.sv
// Round-robin arbiter sharing one quad-XOR gate among N_REQ requesters,
// sequencing each operation through capture, execute and response phases.
module ls86_xor_arbiter
    import ls86_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int GID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [LANES*N_REQ-1:0] req_a,
    input  logic [LANES*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [LANES-1:0]       rsp_y,
    output logic [GID_W-1:0]       grant_id,
    output logic                   busy
);

    state_t             state_reg;
    logic [GID_W-1:0]   ptr_reg;
    logic [GID_W-1:0]   grant_id_reg;
    logic [LANES-1:0]   a_reg;
    logic [LANES-1:0]   b_reg;
    logic [LANES-1:0]   rsp_y_reg;
    logic [LANES-1:0]   xor_y;

    logic [MAX_REQ-1:0] req_vec;
    rr_pick_t           pick;
    logic [LANES-1:0]   a_sel;
    logic [LANES-1:0]   b_sel;
    logic [GID_W-1:0]   gid_sel;
    logic               rsp_ready_sel;

    always_comb begin
        req_vec              = '0;
        req_vec[N_REQ-1:0]   = req_valid;
        pick                 = rr_pick(req_vec, MAX_GID_W'(ptr_reg), N_REQ);
    end

    // Operand/index mux driven by the winner and the response owner.
    always_comb begin
        a_sel         = '0;
        b_sel         = '0;
        gid_sel       = '0;
        rsp_ready_sel = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick.idx == MAX_GID_W'(i)) begin
                a_sel   = req_a[LANES*i +: LANES];
                b_sel   = req_b[LANES*i +: LANES];
                gid_sel = GID_W'(i);
            end
            if (grant_id_reg == GID_W'(i)) begin
                rsp_ready_sel = rsp_ready[i];
            end
        end
    end

    ls86_quad_xor u_quad_xor (
        .a (a_reg),
        .b (b_reg),
        .y (xor_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= '0;
            grant_id_reg <= '0;
            a_reg        <= '0;
            b_reg        <= '0;
            rsp_y_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pick.found) begin
                        a_reg        <= a_sel;
                        b_reg        <= b_sel;
                        grant_id_reg <= gid_sel;
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_reg <= xor_y;
                    state_reg <= RESP;
                end
                RESP: begin
                    if (rsp_ready_sel) begin
                        if (grant_id_reg == GID_W'(N_REQ - 1)) begin
                            ptr_reg <= '0;
                        end else begin
                            ptr_reg <= grant_id_reg + 1'b1;
                        end
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Ready is gated by reset so nothing looks accepted while the block is held.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hs
        assign req_ready[gi] = !rst && (state_reg == IDLE) && pick.found
                               && (pick.idx == MAX_GID_W'(gi));
        assign rsp_valid[gi] = (state_reg == RESP) && (grant_id_reg == GID_W'(gi));
    end

    assign rsp_y    = rsp_y_reg;
    assign grant_id = grant_id_reg;
    assign busy     = (state_reg != IDLE);

endmodule
